execute_mc: RTL and testbench

//  Parametrised execute stage for the LEGv8 datapath.
//  - Combinational ALU path, unchanged from the single-cycle execute stage.
//  - Branch-target adder.
//  - New: iterative shift-add multiplier (MUL). It stalls the pipeline for N+1 cycles while it runs.

---
 rtl/execute_mc.sv | 131 +++++++++++++
 tb/tb_execute_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mc.sv
// Execute stage for the LEGv8 pipeline: combinational ALU, branch-target
// adder, and an iterative shift-add multiplier that stalls the pipeline
// for N+1 cycles while it produces the low N bits of the product.
module execute_mc #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic         MulOp,
   input  logic         AluSrc,
   input  logic [3:0]   AluControl,
   input  logic [N-1:0] PC_E,
   input  logic [N-1:0] signImm_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   output logic [N-1:0] PCBranch_E,
   output logic [N-1:0] aluResult_E,
   output logic [N-1:0] writeData_E,
   output logic         zero_E,
   output logic         stall_E,
   output logic         done_E
);

   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    ma_q, ma_d;     // multiplicand, shifted left each iteration
   logic [N-1:0]    mb_q, mb_d;     // multiplier, shifted right each iteration
   logic [N-1:0]    acc_q, acc_d;   // running partial product
   logic [CW-1:0]   cnt_q, cnt_d;   // iteration counter

   logic [N-1:0]    b_op;
   logic [N-1:0]    alu_y;

   assign b_op        = AluSrc ? signImm_E : readData2_E;
   assign writeData_E = readData2_E;
   assign PCBranch_E  = PC_E + {signImm_E[N-3:0], 2'b00};
   assign zero_E      = (aluResult_E == '0);

   // Combinational ALU; unknown op codes give zero.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      alu_y = '0;
      case (AluControl)
         4'b0000: alu_y = readData1_E & b_op;
         4'b0001: alu_y = readData1_E | b_op;
         4'b0010: alu_y = readData1_E + b_op;
         4'b0110: alu_y = readData1_E + ~b_op + ONE;
         4'b0111: alu_y = b_op;
         4'b1100: alu_y = ~(readData1_E | b_op);
         default: alu_y = '0;
      endcase
   end

   // Multiplier next-state, datapath update and stall/done/result outputs.
   always_comb begin
      state_d     = state_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      stall_E     = 1'b0;
      done_E      = 1'b0;
      aluResult_E = alu_y;

      case (state_q)
         S_IDLE: begin
            if (valid_E && MulOp) begin
               ma_d    = readData1_E;
               mb_d    = b_op;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mb_q[0]) acc_d = acc_q + ma_q;
            ma_d  = ma_q << 1;
            mb_d  = mb_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_DONE;
         end
         S_DONE: begin
            // One-cycle result slot; never restarts even if MulOp is still high.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset is sampled only at the edge, so mask the handshake while it is high.
      if (!reset) begin
         case (state_q)
            S_IDLE:  stall_E = valid_E & MulOp;
            S_BUSY:  stall_E = 1'b1;
            S_DONE: begin
               done_E      = 1'b1;
               aluResult_E = acc_q;
            end
            default: stall_E = 1'b0;
         endcase
      end
   end

   // State and multiplier registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         ma_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc: directed and randomized ALU, branch
// and multiply vectors compared against a plain-arithmetic reference model.
module tb_execute_mc;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_E;
   logic         MulOp;
   logic         AluSrc;
   logic [3:0]   AluControl;
   logic [N-1:0] PC_E;
   logic [N-1:0] signImm_E;
   logic [N-1:0] readData1_E;
   logic [N-1:0] readData2_E;
   logic [N-1:0] PCBranch_E;
   logic [N-1:0] aluResult_E;
   logic [N-1:0] writeData_E;
   logic         zero_E;
   logic         stall_E;
   logic         done_E;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   execute_mc #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_E     (valid_E),
      .MulOp       (MulOp),
      .AluSrc      (AluSrc),
      .AluControl  (AluControl),
      .PC_E        (PC_E),
      .signImm_E   (signImm_E),
      .readData1_E (readData1_E),
      .readData2_E (readData2_E),
      .PCBranch_E  (PCBranch_E),
      .aluResult_E (aluResult_E),
      .writeData_E (writeData_E),
      .zero_E      (zero_E),
      .stall_E     (stall_E),
      .done_E      (done_E)
   );

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference ALU from the op table, using ordinary operators.
   function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return b;
         4'd12:   return ~(a | b);
         default: return '0;
      endcase
   endfunction

   function automatic logic [N-1:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // One combinational ALU/branch vector in a single cycle.
   task automatic alu_vec(input string tag, input logic [3:0] op, input logic src,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] imm, input logic [N-1:0] pc);
      logic [N-1:0] exp_y;
      valid_E     = 1'b1;
      MulOp       = 1'b0;
      AluControl  = op;
      AluSrc      = src;
      readData1_E = a;
      readData2_E = b;
      signImm_E   = imm;
      PC_E        = pc;
      exp_y       = ref_alu(op, a, src ? imm : b);
      sample();
      check({tag, "_res"},   aluResult_E, exp_y);
      check({tag, "_zero"},  N'(zero_E), N'(exp_y == '0));
      check({tag, "_br"},    PCBranch_E, pc + imm * 4);
      check({tag, "_wd"},    writeData_E, b);
      check({tag, "_stall"}, N'(stall_E), '0);
      step();
   endtask

   // Full multiply: latency, stall coverage, result, and return to idle.
   task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] imm, input logic src, input logic poke);
      logic [N-1:0] exp_p;
      int cyc;
      int stalls;
      bit got;
      exp_p       = a * (src ? imm : b);
      valid_E     = 1'b1;
      MulOp       = 1'b1;
      AluSrc      = src;
      AluControl  = 4'b0010;
      readData1_E = a;
      readData2_E = b;
      signImm_E   = imm;
      sample();
      check({tag, "_start_stall"}, N'(stall_E), N'(1));
      stalls = stall_E ? 1 : 0;
      cyc    = 0;
      got    = 1'b0;
      while (!got && cyc < N + 10) begin
         step();
         cyc++;
         if (poke) begin
            readData1_E = rand64();
            readData2_E = rand64();
            signImm_E   = rand64();
         end
         sample();
         if (done_E) got = 1'b1;
         else if (stall_E) stalls++;
      end
      check({tag, "_latency"}, N'(cyc), N'(N + 1));
      check({tag, "_stalls"},  N'(stalls), N'(N + 1));
      check({tag, "_product"}, aluResult_E, exp_p);
      check({tag, "_zero"},    N'(zero_E), N'(exp_p == '0));
      check({tag, "_dstall"},  N'(stall_E), '0);
      check({tag, "_wd"},      writeData_E, readData2_E);
      step();
      valid_E = 1'b0;
      MulOp   = 1'b0;
      sample();
      check({tag, "_idle_done"},  N'(done_E), '0);
      check({tag, "_idle_stall"}, N'(stall_E), '0);
      step();
   endtask

   initial begin
      int bad;
      logic [N-1:0] ra;

      reset       = 1'b1;
      valid_E     = 1'b1;
      MulOp       = 1'b1;
      AluSrc      = 1'b0;
      AluControl  = 4'b0010;
      PC_E        = '0;
      signImm_E   = '0;
      readData1_E = 64'd5;
      readData2_E = 64'd3;

      // Reset phase: handshake outputs masked even with a MUL presented.
      step();
      sample();
      check("rst_stall", N'(stall_E), '0);
      check("rst_done",  N'(done_E), '0);
      check("rst_alu",   aluResult_E, 64'd8);
      step();
      reset   = 1'b0;
      valid_E = 1'b0;
      sample();
      check("post_rst_stall", N'(stall_E), '0);
      check("post_rst_done",  N'(done_E), '0);
      step();

      // Directed ALU and branch cases.
      alu_vec("add",    4'b0010, 1'b0, 64'd5, 64'd3, 64'd0, 64'd0);
      alu_vec("sub0",   4'b0110, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0);
      alu_vec("br_neg", 4'b0010, 1'b0, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000);
      check("br_neg_lit", PCBranch_E, 64'h0FF0);
      alu_vec("br_wrap", 4'b0010, 1'b0, 64'd1, 64'd1, '1, 64'd0);
      alu_vec("undef",  4'b1111, 1'b0, 64'd7, 64'd9, 64'd0, 64'd0);
      alu_vec("nor",    4'b1100, 1'b1, 64'h00F0, 64'd0, 64'h0F00, 64'd4);

      // Randomized ALU vectors over defined and undefined codes.
      for (int i = 0; i < 40; i++) begin
         alu_vec($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 1'($urandom()),
                 rand64(), rand64(), rand64(), rand64());
      end

      // Directed multiplies.
      run_mul("mul7x6",   64'd7, 64'd6, 64'd0, 1'b0, 1'b0);
      run_mul("mul_ovf",  '1, 64'd2, 64'd0, 1'b0, 1'b0);
      run_mul("mul_zero", 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 1'b0, 1'b0);
      run_mul("mul_imm",  64'd4, 64'd55, 64'd3, 1'b1, 1'b1);

      // Reset in the middle of a multiply.
      valid_E     = 1'b1;
      MulOp       = 1'b1;
      AluSrc      = 1'b0;
      AluControl  = 4'b0001;
      readData1_E = 64'd7;
      readData2_E = 64'd5;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      sample();
      check("mid_rst_stall", N'(stall_E), '0);
      check("mid_rst_done",  N'(done_E), '0);
      check("mid_rst_alu",   aluResult_E, 64'd7);
      step();
      reset   = 1'b0;
      valid_E = 1'b0;
      MulOp   = 1'b0;
      bad     = 0;
      for (int i = 0; i < N + 4; i++) begin
         sample();
         if (stall_E || done_E) bad++;
         step();
      end
      check("after_rst_quiet", N'(bad), '0);
      run_mul("mul3x3", 64'd3, 64'd3, 64'd0, 1'b0, 1'b0);

      // Randomized multiplies, some with operand churn during BUSY.
      for (int i = 0; i < 3; i++) begin
         ra = rand64();
         run_mul($sformatf("rmul%0d", i), ra, rand64(), rand64(), 1'($urandom()), 1'($urandom()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
